// File: rtl/ram_bist_ctrl.sv
// RAM self-test controller with an inferred simple dual-port RAM: fills the
// RAM with a seeded pattern, reads it back and reports pass, error count and
// first failing address. Ports: clk, rst_n, start/mode/seed/cont/inj_err in;
// busy/done/pass/err_cnt/first_err_addr and RAM debug taps out.
// Optional feature macro RAM_OUT_REG_EN adds a RAM output register (latency 2).
module ram_bist_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              cont,
  input  logic              inj_err,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic [DATA_W-1:0] ram_rd_data
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   MAX_E  = (ADDR_W+1)'(DEPTH);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [ADDR_W:0]   err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;
  logic              pass_q, pass_d;
  logic              drn_q, drn_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd1_q;
  logic              c1_vld_q, c1_vld_d;
  logic [ADDR_W-1:0] c1_addr_q, c1_addr_d;
  logic [DATA_W-1:0] c1_exp_q, c1_exp_d;

  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] cmp_exp;
  logic [DATA_W-1:0] cmp_dat;
  logic              mism;

  logic              wr_en, rd_en;
  logic [DATA_W-1:0] exp_w;
  logic [DATA_W-1:0] wdata;

  function automatic logic [DATA_W-1:0] pat(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] s,
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] av;
    av = DATA_W'(a);
    case (m)
      2'd0:    pat = s + av;
      2'd1:    pat = s;
      2'd2:    pat = a[0] ? ~s : s;
      default: pat = ~(s + av);
    endcase
  endfunction

  assign wr_en = (state_q == S_WRITE);
  assign rd_en = (state_q == S_READ);
  assign exp_w = pat(mode_q, seed_q, addr_q);
  assign wdata = exp_w ^ {{(DATA_W-1){1'b0}}, inj_err};

  assign ram_wr_en   = wr_en;
  assign ram_wr_addr = wr_en ? addr_q : '0;
  assign ram_wr_data = wr_en ? wdata : '0;
  assign ram_rd_en   = rd_en;
  assign ram_rd_addr = rd_en ? addr_q : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd1_q <= '0;
    else if (rd_en) rd1_q <= mem[addr_q];
  end

  // Expected word and address travel alongside the RAM read latency.
  always_comb begin
    c1_vld_d  = rd_en;
    c1_addr_d = addr_q;
    c1_exp_d  = exp_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1_vld_q  <= 1'b0;
      c1_addr_q <= '0;
      c1_exp_q  <= '0;
    end else begin
      c1_vld_q  <= c1_vld_d;
      c1_addr_q <= c1_addr_d;
      c1_exp_q  <= c1_exp_d;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_W-1:0] rd2_q;
  logic              c2_vld_q;
  logic [ADDR_W-1:0] c2_addr_q;
  logic [DATA_W-1:0] c2_exp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd2_q     <= '0;
      c2_vld_q  <= 1'b0;
      c2_addr_q <= '0;
      c2_exp_q  <= '0;
    end else begin
      rd2_q     <= rd1_q;
      c2_vld_q  <= c1_vld_q;
      c2_addr_q <= c1_addr_q;
      c2_exp_q  <= c1_exp_q;
    end
  end

  assign cmp_dat  = rd2_q;
  assign cmp_vld  = c2_vld_q;
  assign cmp_addr = c2_addr_q;
  assign cmp_exp  = c2_exp_q;
`else
  assign cmp_dat  = rd1_q;
  assign cmp_vld  = c1_vld_q;
  assign cmp_addr = c1_addr_q;
  assign cmp_exp  = c1_exp_q;
`endif

  assign ram_rd_data = cmp_dat;
  assign mism = cmp_vld && (cmp_dat != cmp_exp);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    seed_d  = seed_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    pass_d  = pass_q;
    drn_d   = drn_q;
    if (mism) begin
      if (err_q != MAX_E) err_d = err_q + 1'b1;
      if (err_q == '0) ferr_d = cmp_addr;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          seed_d  = seed;
          err_d   = '0;
          ferr_d  = '0;
          pass_d  = 1'b0;
          addr_d  = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST_A) state_d = S_READ;
      end
      S_READ: begin
        addr_d = addr_q + 1'b1;
        drn_d  = 1'b0;
        if (addr_q == LAST_A) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        drn_d = drn_q + 1'b1;
        if (drn_q == 1'(LAT - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        pass_d = (err_q == '0);
        if (cont) begin
          seed_d  = seed_q + 1'b1;
          err_d   = '0;
          ferr_d  = '0;
          addr_d  = '0;
          state_d = S_WRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      mode_q  <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      pass_q  <= 1'b0;
      drn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      pass_q  <= pass_d;
      drn_q   <= drn_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_q;

endmodule
